i2c_codec_responder: RTL and testbench

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

---
 rtl/i2c_codec_responder_pkg.sv | 33 +++
 rtl/i2c_codec_responder_if.sv | 13 +
 rtl/i2c_codec_responder_sync.sv | 28 ++
 rtl/i2c_codec_responder.sv | 106 ++++++++++
 tb/tb_i2c_codec_responder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/i2c_codec_responder_pkg.sv
// Shared constants for the codec configuration responder: state encoding,
// bus address, register indices and the power-on register table.
package codec_i2c_pkg;

  localparam logic [7:0] DEV_ADDR_DFLT = 8'h34;
  localparam int         NUM_REGS_DFLT = 10;
  localparam logic [6:0] REG_RESET     = 7'd15;
  localparam logic [3:0] REG_R4        = 4'd4;
  localparam logic [3:0] REG_R9        = 4'd9;

  // FSM state encoding
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ACK_A     = 3'd2;
  localparam logic [2:0] BYTE1     = 3'd3;
  localparam logic [2:0] ACK_1     = 3'd4;
  localparam logic [2:0] BYTE2     = 3'd5;
  localparam logic [2:0] ACK_2     = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  function automatic logic [8:0] regDefault(input int idx);
    case (idx)
      0, 1:    regDefault = 9'h097;
      2, 3:    regDefault = 9'h079;
      4:       regDefault = 9'h00A;
      5:       regDefault = 9'h008;
      6:       regDefault = 9'h09F;
      7:       regDefault = 9'h00A;
      default: regDefault = 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Raw bus pins in, synchronized levels and bus events out.
interface i2c_codec_responder_if;
  logic scl;
  logic sdaPin;
  logic sdaS;
  logic sclRise;
  logic sclFall;
  logic startDet;
  logic stopDet;

  modport master (input scl, sdaPin, output sdaS, sclRise, sclFall, startDet, stopDet);
  modport slave  (input sdaS, sclRise, sclFall, startDet, stopDet);
endinterface

// File: rtl/i2c_codec_responder_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.
module i2c_line_sync (
  input  logic                   CLOCK_50,
  input  logic                   iRST_N,
  i2c_codec_responder_if.master  bus
);

  logic sclMeta, sclS, sclPrev;
  logic sdaMeta, sdaS, sdaPrev;

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      sclMeta <= 1'b1; sclS <= 1'b1; sclPrev <= 1'b1;
      sdaMeta <= 1'b1; sdaS <= 1'b1; sdaPrev <= 1'b1;
    end else begin
      sclMeta <= bus.scl;    sclS <= sclMeta; sclPrev <= sclS;
      sdaMeta <= bus.sdaPin; sdaS <= sdaMeta; sdaPrev <= sdaS;
    end
  end

  // START/STOP only count while SCL has been high for two samples
  assign bus.sdaS     = sdaS;
  assign bus.sclRise  = sclS & ~sclPrev;
  assign bus.sclFall  = ~sclS & sclPrev;
  assign bus.startDet = sclS & sclPrev & sdaPrev & ~sdaS;
  assign bus.stopDet  = sclS & sclPrev & ~sdaPrev & sdaS;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder modelling an audio codec's 9-bit register file.
module i2c_codec_responder
  import codec_i2c_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DFLT,
  parameter int         NUM_REGS = NUM_REGS_DFLT
) (
  input  logic       CLOCK_50,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       mic_sel,
  output logic       active,
  output logic       busy
);

  i2c_codec_responder_if lineIf ();
  assign lineIf.scl    = I2C_SCLK;
  assign lineIf.sdaPin = I2C_SDAT;

  i2c_line_sync uSync (.CLOCK_50(CLOCK_50), .iRST_N(iRST_N), .bus(lineIf.master));

  logic [2:0] state;
  logic [2:0] bitCnt;
  logic [7:0] shReg, byte1Q, shNext;
  logic       sdaOe;
  logic [8:0] regs [NUM_REGS];

  assign shNext   = {shReg[6:0], lineIf.sdaS};
  assign I2C_SDAT = sdaOe ? 1'b0 : 1'bz;
  assign busy     = (state != IDLE);
  assign mic_sel  = regs[REG_R4][2];
  assign active   = regs[REG_R9][0];

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NUM_REGS) rd_data = regs[rd_addr];
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shReg    <= '0;
      byte1Q   <= '0;
      sdaOe    <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regDefault(i);
    end else begin
      wr_valid <= 1'b0;
      if (lineIf.startDet) begin
        state  <= ADDR;
        bitCnt <= '0;
        sdaOe  <= 1'b0;
      end else if (lineIf.stopDet) begin
        state <= IDLE;
        sdaOe <= 1'b0;
      end else begin
        case (state)
          ADDR, BYTE1, BYTE2: if (lineIf.sclRise) begin
            shReg  <= shNext;
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              case (state)
                ADDR:    state <= (shNext == DEV_ADDR) ? ACK_A : WAIT_STOP;
                BYTE1:   begin byte1Q <= shNext; state <= ACK_1; end
                default: state <= ACK_2;
              endcase
            end
          end
          ACK_A, ACK_1, ACK_2: begin
            // first SCL fall asserts ACK, second releases it; the rise in between commits
            if (lineIf.sclRise && sdaOe && state == ACK_2) begin
              if (int'(byte1Q[7:1]) < NUM_REGS) begin
                regs[byte1Q[4:1]] <= {byte1Q[0], shReg};
                wr_valid <= 1'b1;
              end else if (byte1Q[7:1] == REG_RESET) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= regDefault(i);
                wr_valid <= 1'b1;
              end
              wr_addr <= byte1Q[7:1];
              wr_data <= {byte1Q[0], shReg};
            end
            if (lineIf.sclFall) begin
              if (!sdaOe) sdaOe <= 1'b1;
              else begin
                sdaOe  <= 1'b0;
                bitCnt <= '0;
                state  <= (state == ACK_A) ? BYTE1 : (state == ACK_1) ? BYTE2 : WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench: bit-banged I2C master, wr_valid monitor, inline checks.
module tb_i2c_codec_responder;

  logic       CLOCK_50 = 1'b0;
  logic       iRST_N   = 1'b0;
  logic       sdaLow   = 1'b0;
  logic [3:0] rd_addr  = 4'd0;
  logic [8:0] rd_data;
  logic       wr_valid, mic_sel, active, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  wire        sda;

  i2c_codec_responder_if lineBus ();

  assign sda = sdaLow ? 1'b0 : 1'bz;
  pullup (sda);
  assign lineBus.sdaPin = sda;

  i2c_codec_responder dut (
    .CLOCK_50(CLOCK_50), .iRST_N(iRST_N), .I2C_SCLK(lineBus.scl), .I2C_SDAT(sda),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .mic_sel(mic_sel), .active(active), .busy(busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int nTests = 0, nFail = 0;
  int cyc = 0, wrCnt = 0, lastWrCyc = 0, ackRiseCyc = 0;
  logic [6:0] lastAddr;
  logic [8:0] lastData;

  always @(posedge CLOCK_50) cyc++;
  always @(negedge CLOCK_50) if (wr_valid) begin
    wrCnt++; lastAddr = wr_addr; lastData = wr_data; lastWrCyc = cyc;
  end

  task automatic hc(input int n); repeat (n) @(negedge CLOCK_50); endtask

  task automatic readReg(input logic [3:0] a, output logic [8:0] d);
    rd_addr = a; #1 d = rd_data;
  endtask

  task automatic i2cStart;
    hc(3); sdaLow = 1'b0; hc(7); lineBus.scl = 1'b1; hc(10);
    sdaLow = 1'b1; hc(10); lineBus.scl = 1'b0;
  endtask

  task automatic i2cStop;
    hc(3); sdaLow = 1'b1; hc(7); lineBus.scl = 1'b1; hc(10); sdaLow = 1'b0; hc(10);
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      hc(3); sdaLow = ~b[7-i]; hc(7); lineBus.scl = 1'b1; hc(10); lineBus.scl = 1'b0;
    end
  endtask

  // returns SDA seen on the 9th SCL high and SDA shortly after the 9th fall
  task automatic ackClock(output logic ack, output logic rel);
    hc(3); sdaLow = 1'b0; hc(7); lineBus.scl = 1'b1; ackRiseCyc = cyc;
    hc(5); ack = sda; hc(5); lineBus.scl = 1'b0; hc(5); rel = sda;
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack, output logic rel);
    sendBits(b, 8); ackClock(ack, rel);
  endtask

  task automatic test_reset;
    logic [8:0] d;
    readReg(4'd0, d); nTests++;
    if (d !== 9'h097) begin nFail++; $display("FAIL reset_r0 got %h want 097", d); end
    readReg(4'd4, d); nTests++;
    if (d !== 9'h00A) begin nFail++; $display("FAIL reset_r4 got %h want 00A", d); end
    nTests++; if (sda !== 1'b1) begin nFail++; $display("FAIL reset_sda got %b want 1", sda); end
    nTests++; if (wr_valid !== 1'b0 || wr_addr !== 7'd0 || wr_data !== 9'd0) begin
      nFail++; $display("FAIL reset_wr got %b/%h/%h want 0/0/0", wr_valid, wr_addr, wr_data); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", busy); end
    hc(3); iRST_N = 1'b1; hc(3);
  endtask

  task automatic test_wrong_addr;
    logic a0, a1, a2, r; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h36, a0, r); sendByte(8'h08, a1, r); sendByte(8'h15, a2, r); i2cStop();
    nTests++; if ({a0, a1, a2} !== 3'b111) begin nFail++; $display("FAIL nack_addr got %b want 111", {a0, a1, a2}); end
    nTests++; if (wrCnt !== w0) begin nFail++; $display("FAIL nack_nowrite got %0d want %0d", wrCnt, w0); end
    readReg(4'd4, d); nTests++;
    if (d !== 9'h00A) begin nFail++; $display("FAIL nack_r4 got %h want 00A", d); end
  endtask

  task automatic test_write_r4;
    logic a0, a1, a2, r0, r1, r2; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h34, a0, r0); sendByte(8'h08, a1, r1); sendByte(8'h15, a2, r2);
    nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL wr_busy got %b want 1", busy); end
    i2cStop();
    nTests++; if ({a0, a1, a2} !== 3'b000) begin nFail++; $display("FAIL wr_acks got %b want 000", {a0, a1, a2}); end
    nTests++; if ({r0, r1, r2} !== 3'b111) begin nFail++; $display("FAIL wr_ack_release got %b want 111", {r0, r1, r2}); end
    nTests++; if (wrCnt !== w0 + 1 || lastAddr !== 7'd4 || lastData !== 9'h015) begin
      nFail++; $display("FAIL wr_commit got n=%0d %h/%h want n=%0d 04/015", wrCnt - w0, lastAddr, lastData, 1); end
    nTests++; if (lastWrCyc - ackRiseCyc > 4 || lastWrCyc < ackRiseCyc) begin
      nFail++; $display("FAIL wr_latency got %0d want <=4", lastWrCyc - ackRiseCyc); end
    nTests++; if (mic_sel !== 1'b1) begin nFail++; $display("FAIL wr_mic_sel got %b want 1", mic_sel); end
    readReg(4'd4, d); nTests++;
    if (d !== 9'h015) begin nFail++; $display("FAIL wr_r4 got %h want 015", d); end
  endtask

  task automatic test_reg_reset;
    logic a, r; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h34, a, r); sendByte(8'h12, a, r); sendByte(8'h01, a, r); i2cStop();
    nTests++; if (active !== 1'b1) begin nFail++; $display("FAIL r9_active got %b want 1", active); end
    i2cStart(); sendByte(8'h34, a, r); sendByte(8'h1E, a, r); sendByte(8'h00, a, r); i2cStop();
    nTests++; if (wrCnt !== w0 + 2 || lastAddr !== 7'd15 || lastData !== 9'h000) begin
      nFail++; $display("FAIL rst_commit got n=%0d %h/%h want n=2 0f/000", wrCnt - w0, lastAddr, lastData); end
    nTests++; if (active !== 1'b0 || mic_sel !== 1'b0) begin
      nFail++; $display("FAIL rst_flags got %b%b want 00", active, mic_sel); end
    readReg(4'd4, d); nTests++;
    if (d !== 9'h00A) begin nFail++; $display("FAIL rst_r4 got %h want 00A", d); end
    readReg(4'd6, d); nTests++;
    if (d !== 9'h09F) begin nFail++; $display("FAIL rst_r6 got %h want 09F", d); end
    readReg(4'd9, d); nTests++;
    if (d !== 9'h000) begin nFail++; $display("FAIL rst_r9 got %h want 000", d); end
  endtask

  task automatic test_repeated_start;
    logic a, r, a2; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h34, a, r); sendByte(8'h0E, a, r);
    i2cStart(); sendByte(8'h34, a, r); sendByte(8'h0E, a, r); sendByte(8'h4D, a2, r); i2cStop();
    nTests++; if (wrCnt !== w0 + 1 || lastAddr !== 7'd7 || lastData !== 9'h04D) begin
      nFail++; $display("FAIL rs_commit got n=%0d %h/%h want n=1 07/04D", wrCnt - w0, lastAddr, lastData); end
    readReg(4'd7, d); nTests++;
    if (d !== 9'h04D) begin nFail++; $display("FAIL rs_r7 got %h want 04D", d); end
  endtask

  task automatic test_third_byte;
    logic a0, a1, a2, a3, r; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h34, a0, r); sendByte(8'h04, a1, r); sendByte(8'h55, a2, r);
    sendByte(8'hAA, a3, r); i2cStop();
    nTests++; if ({a0, a1, a2, a3} !== 4'b0001) begin nFail++; $display("FAIL b3_acks got %b want 0001", {a0, a1, a2, a3}); end
    nTests++; if (wrCnt !== w0 + 1) begin nFail++; $display("FAIL b3_count got %0d want 1", wrCnt - w0); end
    readReg(4'd2, d); nTests++;
    if (d !== 9'h055) begin nFail++; $display("FAIL b3_r2 got %h want 055", d); end
  endtask

  task automatic test_out_of_range;
    logic a0, a1, a2, r; logic [8:0] d; int w0 = wrCnt;
    i2cStart(); sendByte(8'h34, a0, r); sendByte(8'h14, a1, r); sendByte(8'h33, a2, r); i2cStop();
    nTests++; if ({a0, a1, a2} !== 3'b000 || wrCnt !== w0) begin
      nFail++; $display("FAIL oor got acks %b n=%0d want 000 n=0", {a0, a1, a2}, wrCnt - w0); end
    readReg(4'd10, d); nTests++;
    if (d !== 9'h000) begin nFail++; $display("FAIL oor_rd10 got %h want 000", d); end
  endtask

  task automatic test_mid_reset;
    logic a, r; logic [8:0] d; int w0 = wrCnt;
    // reset while the responder is actively driving an ACK
    i2cStart(); sendBits(8'h34, 8); hc(3); sdaLow = 1'b0; hc(3);
    nTests++; if (sda !== 1'b0) begin nFail++; $display("FAIL mr_ack got %b want 0", sda); end
    iRST_N = 1'b0; #1;
    nTests++; if (sda !== 1'b1) begin nFail++; $display("FAIL mr_release got %b want 1", sda); end
    hc(3); iRST_N = 1'b1; i2cStop();
    // reset in the middle of the second data byte
    i2cStart(); sendByte(8'h34, a, r); sendByte(8'h08, a, r); sendBits(8'h15, 4);
    iRST_N = 1'b0; #1;
    nTests++; if (sda !== 1'b1 || busy !== 1'b0) begin
      nFail++; $display("FAIL mr_b2 got sda=%b busy=%b want 1/0", sda, busy); end
    hc(3); iRST_N = 1'b1; sendBits(8'h50, 4); ackClock(a, r); i2cStop();
    nTests++; if (a !== 1'b1 || wrCnt !== w0) begin
      nFail++; $display("FAIL mr_nocommit got ack=%b n=%0d want 1 n=0", a, wrCnt - w0); end
    readReg(4'd4, d); nTests++;
    if (d !== 9'h00A) begin nFail++; $display("FAIL mr_r4 got %h want 00A", d); end
  endtask

  initial begin
    lineBus.scl = 1'b1;
    hc(4);
    test_reset();
    test_wrong_addr();
    test_write_r4();
    test_reg_reset();
    test_repeated_start();
    test_third_byte();
    test_out_of_range();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
